// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy bank: scheduler states and sprite geometry.
package enemy_pkg;

    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned COLOUR_W = 6;

    // Colour value an enemy sprite uses for "do not paint this pixel".
    localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 6'b111111;

    // Pixels in one enemy sprite (16x16).
    localparam int unsigned SPRITE_PIXELS = 256;

    typedef enum logic [3:0] {
        S_WAIT_START,
        S_INIT,
        S_IDLE,
        S_HIT,
        S_GEN,
        S_APPLY,
        S_DRAW,
        S_GAP,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/enemy_vga_mux.sv
// N-to-1 selector placing one enemy's pixel stream onto the shared VGA write port.
module enemy_vga_mux
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES = 4,
    parameter int unsigned IDX_W       = 3
) (
    input  logic [IDX_W-1:0]                  idx,
    input  logic                              active,
    input  logic [NUM_ENEMIES*X_W-1:0]        enemy_x_draw,
    input  logic [NUM_ENEMIES*Y_W-1:0]        enemy_y_draw,
    input  logic [NUM_ENEMIES*COLOUR_W-1:0]   enemy_colour,
    input  logic [NUM_ENEMIES-1:0]            enemy_vga_write,
    output logic [X_W-1:0]                    vga_x,
    output logic [Y_W-1:0]                    vga_y,
    output logic [COLOUR_W-1:0]               vga_colour,
    output logic                              vga_write
);

    logic sel_write;

    // Pick enemy idx's fields; write enable only passes while that enemy is drawing.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        sel_write  = 1'b0;
        for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            if (idx == IDX_W'(i)) begin
                vga_x      = enemy_x_draw[i*X_W +: X_W];
                vga_y      = enemy_y_draw[i*Y_W +: Y_W];
                vga_colour = enemy_colour[i*COLOUR_W +: COLOUR_W];
                sel_write  = enemy_vga_write[i];
            end
        end
        vga_write = active & sel_write;
    end

endmodule

// File: rtl/enemy_scheduler.sv
// Steps the enemy bank through hit / move / draw phases once per frame and arbitrates
// the single VGA write port so enemies are drawn strictly one after another.
module enemy_scheduler
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES = 4,
    parameter int unsigned IDX_W       = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              frame_tick,
    input  logic [NUM_ENEMIES-1:0]            enemy_enable,
    input  logic [NUM_ENEMIES-1:0]            hit_req,
    input  logic [NUM_ENEMIES-1:0]            enemy_draw_done,
    input  logic [NUM_ENEMIES*X_W-1:0]        enemy_x_draw,
    input  logic [NUM_ENEMIES*Y_W-1:0]        enemy_y_draw,
    input  logic [NUM_ENEMIES*COLOUR_W-1:0]   enemy_colour,
    input  logic [NUM_ENEMIES-1:0]            enemy_vga_write,
    output logic                              enemy_init,
    output logic                              enemy_idle,
    output logic [NUM_ENEMIES-1:0]            enemy_gen_move,
    output logic [NUM_ENEMIES-1:0]            enemy_apply_move,
    output logic [NUM_ENEMIES-1:0]            enemy_draw,
    output logic [NUM_ENEMIES-1:0]            enemy_hit,
    output logic [X_W-1:0]                    vga_x,
    output logic [Y_W-1:0]                    vga_y,
    output logic [COLOUR_W-1:0]               vga_colour,
    output logic                              vga_write,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              frame_overrun
);

    sched_state_t            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_ENEMIES-1:0]  hit_pending_q, hit_pending_d;
    logic                    overrun_q, overrun_d;

    logic [IDX_W-1:0]        first_idx, next_idx;
    logic                    first_found, next_found;
    logic [NUM_ENEMIES-1:0]  idx_onehot;
    logic                    cur_done;
    logic                    drawing;

    // Priority encoder: lowest enabled enemy, and lowest enabled enemy above idx.
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        next_idx    = '0;
        next_found  = 1'b0;
        idx_onehot  = '0;
        // Scan downwards so the last hit taken is the lowest index.
        for (int i = int'(NUM_ENEMIES) - 1; i >= 0; i--) begin
            idx_onehot[i] = (idx_q == IDX_W'(i));
            if (enemy_enable[i]) begin
                first_idx   = IDX_W'(i);
                first_found = 1'b1;
                if (IDX_W'(i) > idx_q) begin
                    next_idx   = IDX_W'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    assign cur_done = |(idx_onehot & enemy_draw_done);
    assign drawing  = (state_q == S_DRAW);

    // State, index, pending-hit and overrun registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_WAIT_START;
            idx_q         <= '0;
            hit_pending_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hit_pending_q <= hit_pending_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic for the frame schedule.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hit_pending_d = hit_pending_q;
        overrun_d     = overrun_q;

        unique case (state_q)
            S_WAIT_START: state_d = S_WAIT_START;
            S_INIT: begin
                hit_pending_d = '0;
                overrun_d     = 1'b0;
                state_d       = S_IDLE;
            end
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = (|(hit_pending_q & enemy_enable)) ? S_HIT : S_GEN;
                end
            end
            S_HIT: begin
                hit_pending_d = hit_pending_q & ~enemy_enable;
                state_d       = S_GEN;
            end
            S_GEN:   state_d = S_APPLY;
            S_APPLY: begin
                if (first_found) begin
                    idx_d   = first_idx;
                    state_d = S_DRAW;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRAW: begin
                if (cur_done) state_d = S_GAP;
            end
            S_GAP: begin
                if (next_found) begin
                    idx_d   = next_idx;
                    state_d = S_DRAW;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_WAIT_START;
        endcase

        // A new hit applied after the S_HIT clear so it survives to the next frame.
        if (state_q != S_WAIT_START) hit_pending_d = hit_pending_d | hit_req;
        if (frame_tick && busy) overrun_d = 1'b1;
        // Restart overrides everything; reset is handled in the register.
        if (start) state_d = S_INIT;
    end

    // Moore output decode of the registered state.
    always_comb begin
        enemy_init       = (state_q == S_INIT);
        enemy_idle       = (state_q == S_WAIT_START) || (state_q == S_IDLE);
        enemy_hit        = (state_q == S_HIT)   ? (hit_pending_q & enemy_enable) : '0;
        enemy_gen_move   = (state_q == S_GEN)   ? enemy_enable : '0;
        enemy_apply_move = (state_q == S_APPLY) ? enemy_enable : '0;
        enemy_draw       = drawing ? idx_onehot : '0;
        busy             = (state_q == S_HIT) || (state_q == S_GEN) || (state_q == S_APPLY) ||
                           (state_q == S_DRAW) || (state_q == S_GAP) || (state_q == S_DONE);
        frame_done       = (state_q == S_DONE);
        frame_overrun    = overrun_q;
    end

    enemy_vga_mux #(
        .NUM_ENEMIES (NUM_ENEMIES),
        .IDX_W       (IDX_W)
    ) u_vga_mux (
        .idx             (idx_q),
        .active          (drawing),
        .enemy_x_draw    (enemy_x_draw),
        .enemy_y_draw    (enemy_y_draw),
        .enemy_colour    (enemy_colour),
        .enemy_vga_write (enemy_vga_write),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_colour      (vga_colour),
        .vga_write       (vga_write)
    );

endmodule

// File: tb/tb_enemy_scheduler.sv
// Bench for enemy_scheduler: control-path vector table, hand-written corner sequences and
// randomized frames checked against a per-frame schedule built from the phase rules.
module tb_enemy_scheduler;
    import enemy_pkg::*;

    localparam int N = 4;

    logic                clock = 1'b0;
    logic                reset, start, frame_tick;
    logic [N-1:0]        enemy_enable, hit_req, enemy_draw_done, enemy_vga_write;
    logic [N*9-1:0]      enemy_x_draw;
    logic [N*8-1:0]      enemy_y_draw;
    logic [N*6-1:0]      enemy_colour;
    logic                enemy_init, enemy_idle;
    logic [N-1:0]        enemy_gen_move, enemy_apply_move, enemy_draw, enemy_hit;
    logic [8:0]          vga_x;
    logic [7:0]          vga_y;
    logic [5:0]          vga_colour;
    logic                vga_write, busy, frame_done, frame_overrun;

    enemy_scheduler #(
        .NUM_ENEMIES (N),
        .IDX_W       (3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .frame_tick       (frame_tick),
        .enemy_enable     (enemy_enable),
        .hit_req          (hit_req),
        .enemy_draw_done  (enemy_draw_done),
        .enemy_x_draw     (enemy_x_draw),
        .enemy_y_draw     (enemy_y_draw),
        .enemy_colour     (enemy_colour),
        .enemy_vga_write  (enemy_vga_write),
        .enemy_init       (enemy_init),
        .enemy_idle       (enemy_idle),
        .enemy_gen_move   (enemy_gen_move),
        .enemy_apply_move (enemy_apply_move),
        .enemy_draw       (enemy_draw),
        .enemy_hit        (enemy_hit),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_colour       (vga_colour),
        .vga_write        (vga_write),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_overrun    (frame_overrun)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Behavioural enemy: cnt counts cycles it has seen draw high; P pixels then draw_done.
    int cnt[N];
    int pix[N];
    // Reference state: pending hits and sticky overrun.
    logic [N-1:0] pend;
    logic         ov;

    typedef struct {
        logic         init, idle;
        logic [N-1:0] hit, gen, apply, draw;
        logic         done, busy;
        int           idx;
    } rec_t;

    typedef struct {
        logic         rst, st, tk;
        logic [N-1:0] en;
        logic         e_init, e_idle;
        logic [N-1:0] e_gen, e_apply, e_draw;
        logic         e_done, e_busy;
    } vec_t;

    function automatic logic [8:0] ex(int i); return 9'(i * 40 + cnt[i]); endfunction
    function automatic logic [7:0] ey(int i); return 8'(i * 50 + cnt[i]); endfunction
    function automatic logic [5:0] ec(int i); return 6'(i * 7 + cnt[i]); endfunction

    function automatic rec_t mk(logic init, logic idle, logic [N-1:0] hit, logic [N-1:0] gen,
                                logic [N-1:0] apply, logic [N-1:0] draw, logic done,
                                logic bsy, int idx);
        rec_t r;
        r.init = init; r.idle = idle; r.hit = hit; r.gen = gen; r.apply = apply;
        r.draw = draw; r.done = done; r.busy = bsy; r.idx = idx;
        return r;
    endfunction

    task automatic drive_enemies();
        for (int i = 0; i < N; i++) begin
            enemy_x_draw[i*9 +: 9] = ex(i);
            enemy_y_draw[i*8 +: 8] = ey(i);
            enemy_colour[i*6 +: 6] = ec(i);
            enemy_vga_write[i]     = (cnt[i] < pix[i]);
            enemy_draw_done[i]     = (cnt[i] >= pix[i]);
        end
    endtask

    // One clock: enemies react to the draw strobe seen before the edge, then settle.
    task automatic step();
        logic [N-1:0] d;
        d = enemy_draw;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) cnt[i] = d[i] ? cnt[i] + 1 : 0;
        drive_enemies();
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_rec(input string name, input rec_t r);
        logic vw;
        vw = 1'b0;
        if (r.draw != '0 && r.idx >= 0) vw = enemy_vga_write[r.idx];
        chk(name, 64'({enemy_init, enemy_idle, enemy_hit, enemy_gen_move, enemy_apply_move,
                       enemy_draw, frame_done, busy, frame_overrun, vga_write}),
                  64'({r.init, r.idle, r.hit, r.gen, r.apply, r.draw, r.done, r.busy, ov, vw}));
        if (r.idx >= 0)
            chk({name, " vga"}, 64'({vga_x, vga_y, vga_colour}),
                64'({ex(r.idx), ey(r.idx), ec(r.idx)}));
    endtask

    // Run one frame from S_IDLE, comparing every cycle against a schedule built from the
    // phase rules: [hit] gen apply { draw x(P+1), gap } per enabled enemy, done.
    task automatic run_frame(input logic [N-1:0] en, input int p, input bit rnd,
                             input int req_at, input logic [N-1:0] req_bits,
                             input int tick_at, output int done_at);
        rec_t         q[$];
        logic [N-1:0] hm;
        int           last;
        bit           set_ov;
        for (int i = 0; i < N; i++) pix[i] = p;
        enemy_enable = en;
        drive_enemies();
        step();
        chk("idle before frame", 64'({enemy_idle, busy}), 64'(2'b10));

        hm   = pend & en;
        pend = pend & ~hm;
        last = -1;
        if (hm != '0) q.push_back(mk(0, 0, hm, '0, '0, '0, 0, 1, -1));
        q.push_back(mk(0, 0, '0, en, '0, '0, 0, 1, -1));
        q.push_back(mk(0, 0, '0, '0, en, '0, 0, 1, -1));
        for (int k = 0; k < N; k++) begin
            if (en[k]) begin
                for (int j = 0; j <= p; j++) q.push_back(mk(0, 0, '0, '0, '0, N'(1) << k, 0, 1, k));
                q.push_back(mk(0, 0, '0, '0, '0, '0, 0, 1, k));
                last = k;
            end
        end
        q.push_back(mk(0, 0, '0, '0, '0, '0, 1, 1, last));

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        done_at = -1;
        for (int c = 0; c < q.size(); c++) begin
            check_rec($sformatf("frame en=%b cycle %0d", en, c + 1), q[c]);
            if (frame_done && done_at < 0) done_at = c + 1;
            hit_req = (c == req_at) ? req_bits :
                      ((rnd && $urandom_range(15) == 0) ? N'($urandom) : '0);
            frame_tick = (c == tick_at) || (rnd && $urandom_range(63) == 0);
            set_ov = frame_tick && q[c].busy;
            pend = pend | hit_req;
            step();
            if (set_ov) ov = 1'b1;
            hit_req    = '0;
            frame_tick = 1'b0;
        end
        check_rec($sformatf("idle after frame en=%b", en), mk(0, 1, '0, '0, '0, '0, 0, 0, last));
    endtask

    // Start a frame with all enemies enabled and stop once enemy 1 has drawn a few cycles.
    task automatic run_into_draw1(input string name);
        int seen;
        enemy_enable = '1;
        for (int i = 0; i < N; i++) pix[i] = 8;
        drive_enemies();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        seen = 0;
        for (int c = 0; c < 60 && seen < 3; c++) begin
            step();
            if (enemy_draw == 4'b0010) seen++;
        end
        chk({name, " reached draw of enemy 1"}, 64'(seen), 64'(3));
    endtask

    vec_t tbl[18];
    int   d;

    initial begin
        // rst st tk en  | init idle gen apply draw done busy
        tbl[0]  = '{1, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[1]  = '{0, 0, 1, 4'b0000, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[2]  = '{0, 1, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[3]  = '{0, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[4]  = '{0, 0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1};
        tbl[5]  = '{0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1};
        tbl[6]  = '{0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1};
        tbl[7]  = '{0, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[8]  = '{0, 0, 1, 4'b0101, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0, 1};
        tbl[9]  = '{0, 0, 0, 4'b0101, 0, 0, 4'b0000, 4'b0101, 4'b0000, 0, 1};
        tbl[10] = '{0, 0, 0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 4'b0001, 0, 1};
        tbl[11] = '{0, 1, 0, 4'b0101, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[12] = '{0, 0, 0, 4'b0101, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[13] = '{0, 0, 1, 4'b0100, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 1};
        tbl[14] = '{0, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0100, 4'b0000, 0, 1};
        tbl[15] = '{0, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0100, 0, 1};
        tbl[16] = '{0, 1, 0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[17] = '{0, 0, 0, 4'b0100, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0};

        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        enemy_enable = '0; hit_req = '0;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; pix[i] = 4; end
        drive_enemies();
        pend = '0;
        ov   = 1'b0;

        for (int v = 0; v < 18; v++) begin
            reset = tbl[v].rst; start = tbl[v].st; frame_tick = tbl[v].tk;
            enemy_enable = tbl[v].en;
            step();
            chk($sformatf("vector %0d", v),
                64'({enemy_init, enemy_idle, enemy_gen_move, enemy_apply_move, enemy_draw,
                     frame_done, busy}),
                64'({tbl[v].e_init, tbl[v].e_idle, tbl[v].e_gen, tbl[v].e_apply,
                     tbl[v].e_draw, tbl[v].e_done, tbl[v].e_busy}));
        end
        reset = 1'b0; start = 1'b0; frame_tick = 1'b0;

        // Full-size sprites, all enabled: 3 + 4 * (256 + 2) cycles to frame_done.
        run_frame(4'b1111, SPRITE_PIXELS, 0, -1, '0, -1, d);
        chk("frame_done latency 4 enemies", 64'(d), 64'(1035));
        run_frame(4'b1010, 3, 0, -1, '0, -1, d);
        run_frame(4'b0000, 3, 0, -1, '0, -1, d);
        chk("frame_done latency no enemies", 64'(d), 64'(3));

        // Hit during a draw, then a hit coincident with the S_HIT cycle, then a disabled target.
        run_frame(4'b1111, 2, 0, 5, 4'b0100, -1, d);
        run_frame(4'b1111, 2, 0, 0, 4'b0100, -1, d);
        run_frame(4'b1011, 2, 0, -1, '0, -1, d);
        run_frame(4'b1111, 2, 0, -1, '0, -1, d);

        // Tick while drawing: overrun sticks, no extra frame.
        run_frame(4'b1111, 3, 0, -1, '0, 6, d);
        run_frame(4'b0011, 2, 0, -1, '0, -1, d);

        // Restart mid-draw of enemy 1.
        run_into_draw1("restart");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start mid-draw", 64'({enemy_init, enemy_draw, vga_write, busy}), 64'(7'b1_0000_0_0));
        step();
        chk("idle after restart", 64'({enemy_idle, busy, frame_overrun}), 64'(3'b100));
        pend = '0;
        ov   = 1'b0;

        // Reset mid-draw of enemy 1.
        run_into_draw1("reset");
        reset = 1'b1;
        step();
        chk("reset mid-draw",
            64'({enemy_init, enemy_idle, enemy_gen_move, enemy_apply_move, enemy_draw, enemy_hit,
                 busy, frame_done, frame_overrun, vga_write}),
            64'({1'b0, 1'b1, 16'h0, 4'b0000}));
        chk("reset mid-draw vga", 64'({vga_x, vga_y, vga_colour}), 64'(0));
        reset = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("tick ignored before start", 64'({enemy_idle, busy, enemy_gen_move}), 64'(6'b10_0000));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pend = '0;
        ov   = 1'b0;

        // Randomized frames with stray hit requests and ticks.
        for (int f = 0; f < 40; f++) begin
            run_frame(N'($urandom), int'($urandom_range(4, 1)), 1, -1, '0, -1, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
